// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Counts apple-eat events into a 4-digit BCD score, tracks the
//             session high score and scans an active-low 7-segment display.
//  Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int POINTS       = 1,
    parameter int LOCKOUT      = 1024,
    parameter int REFRESH_BITS = 18
) (
    input  logic        VGA_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        game_over,
    input  logic        score_increment,
    input  logic        show_high,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic        playing,
    output logic        new_high,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int c_lock_w = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [c_lock_w-1:0]     c_lock_load = c_lock_w'(LOCKOUT - 1);
    localparam logic [c_lock_w-1:0]     c_lock_one  = c_lock_w'(1);
    localparam logic [REFRESH_BITS-1:0] c_ref_one   = REFRESH_BITS'(1);
    localparam logic [4:0]              c_points    = 5'(POINTS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_prev_inc;
    logic [c_lock_w-1:0]     r_lock;
    logic [15:0]             r_score;
    logic [15:0]             r_high;
    logic                    r_new_high;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_an;
    logic [6:0]              r_seg;

    logic        w_rise;
    logic        w_count;
    logic        w_clear_score;
    logic        w_end_game;
    logic [15:0] w_sum;
    logic [1:0]  w_sel;
    logic [15:0] w_word;
    logic [3:0]  w_nibble;
    logic [3:0]  w_an;
    logic [6:0]  w_seg;

    // ------------------------------------------------------------------
    // Game-phase FSM
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_clear_score = 1'b0;
        w_end_game    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next  = S_PLAYING;
                    w_clear_score = 1'b1;
                end
            end
            S_PLAYING: begin
                if (game_over) begin
                    w_state_next = S_OVER;
                    w_end_game   = 1'b1;
                end
            end
            S_OVER: begin
                if (start) begin
                    w_state_next  = S_PLAYING;
                    w_clear_score = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Eat-event detection with post-event lockout
    // ------------------------------------------------------------------
    assign w_rise  = score_increment & ~r_prev_inc;
    // game_over on the same edge drops the event so the high-score compare
    // sees the pre-event score.
    assign w_count = (r_state == S_PLAYING) && !game_over && w_rise &&
                     (r_lock == '0);

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            r_prev_inc <= 1'b0;
            r_lock     <= '0;
        end else begin
            r_prev_inc <= score_increment;
            if (w_count) begin
                r_lock <= c_lock_load;
            end else if (r_lock != '0) begin
                r_lock <= r_lock - c_lock_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating BCD adder: POINTS enters the ones digit, carries ripple up
    // ------------------------------------------------------------------
    always_comb begin
        logic [4:0] v_digit;
        logic       v_carry;
        w_sum   = '0;
        v_carry = 1'b0;
        v_digit = '0;
        for (int i = 0; i < 4; i++) begin
            v_digit = {1'b0, r_score[4*i +: 4]} + {4'd0, v_carry} +
                      ((i == 0) ? c_points : 5'd0);
            if (v_digit > 5'd9) begin
                v_digit = v_digit - 5'd10;
                v_carry = 1'b1;
            end else begin
                v_carry = 1'b0;
            end
            w_sum[4*i +: 4] = v_digit[3:0];
        end
        if (v_carry) begin
            w_sum = 16'h9999;
        end
    end

    // ------------------------------------------------------------------
    // Score and high-score registers
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            if (w_clear_score) begin
                r_score    <= '0;
                r_new_high <= 1'b0;
            end else if (w_count) begin
                r_score <= w_sum;
            end
            // Valid BCD words order the same way as binary, so a plain
            // magnitude compare is a correct BCD compare.
            if (w_end_game && (r_score > r_high)) begin
                r_high     <= r_score;
                r_new_high <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan: free-running refresh counter, registered an/seg
    // ------------------------------------------------------------------
    assign w_sel  = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_word = show_high ? r_high : r_score;

    always_comb begin
        w_an     = 4'b1110;
        w_nibble = w_word[3:0];
        case (w_sel)
            2'd0: begin
                w_an     = 4'b1110;
                w_nibble = w_word[3:0];
            end
            2'd1: begin
                w_an     = 4'b1101;
                w_nibble = w_word[7:4];
            end
            2'd2: begin
                w_an     = 4'b1011;
                w_nibble = w_word[11:8];
            end
            default: begin
                w_an     = 4'b0111;
                w_nibble = w_word[15:12];
            end
        endcase
    end

    always_comb begin
        w_seg = 7'b1111111;
        case (w_nibble)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_an      <= 4'b1110;
            r_seg     <= 7'b1000000;
        end else begin
            r_refresh <= r_refresh + c_ref_one;
            r_an      <= w_an;
            r_seg     <= w_seg;
        end
    end

    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign playing   = (r_state == S_PLAYING);
    assign new_high  = r_new_high;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Self-checking bench for score_keeper (two parameterisations).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    localparam int LOCK_A = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, go_a, inc_a, sh_a;
    logic        start_b, go_b, inc_b, sh_b;
    logic [15:0] score_a, high_a, score_b, high_b;
    logic        play_a, nh_a, play_b, nh_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;

    score_keeper #(.POINTS(1), .LOCKOUT(LOCK_A), .REFRESH_BITS(4)) dut_a (
        .VGA_clk(clk), .reset(reset), .start(start_a), .game_over(go_a),
        .score_increment(inc_a), .show_high(sh_a), .score_bcd(score_a),
        .high_bcd(high_a), .playing(play_a), .new_high(nh_a), .an(an_a), .seg(seg_a)
    );

    score_keeper #(.POINTS(5), .LOCKOUT(2), .REFRESH_BITS(4)) dut_b (
        .VGA_clk(clk), .reset(reset), .start(start_b), .game_over(go_b),
        .score_increment(inc_b), .show_high(sh_b), .score_bcd(score_b),
        .high_bcd(high_b), .playing(play_b), .new_high(nh_b), .an(an_b), .seg(seg_b)
    );

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int sc_a = 0;
    int sc_b = 0;

    always @(posedge clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic       sh;
        int         sel;
        logic [3:0] an;
        logic [6:0] seg;
    } disp_t;
    disp_t dt[8];

    logic [6:0] seg_tab [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [3:0] an_for(input int sel);
        case (sel)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic push(input string name, input logic [15:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] act);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got %h expected an entry", act);
        end else begin
            e = exp_q.pop_front();
            chk(e.name, act, e.val);
        end
    endtask

    // One-cycle pulse whose rising edge is followed by the next pulse 'gap' edges later
    task automatic ev_a(input int gap);
        inc_a = 1'b1;
        tick();
        inc_a = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic ev_b(input int gap);
        inc_b = 1'b1;
        tick();
        inc_b = 1'b0;
        repeat (gap - 1) tick();
    endtask

    function automatic int cur_sel();
        return (edge_cnt == 0) ? 0 : (((edge_cnt - 1) >> 2) & 3);
    endfunction

    function automatic int cur_phase();
        return (edge_cnt == 0) ? 0 : ((edge_cnt - 1) & 3);
    endfunction

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

        reset = 1'b1;
        start_a = 0; go_a = 0; inc_a = 0; sh_a = 0;
        start_b = 0; go_b = 0; inc_b = 0; sh_b = 0;
        repeat (3) tick();

        chk("rst_score", score_a, 16'h0000);
        chk("rst_high", high_a, 16'h0000);
        chk("rst_playing", {15'd0, play_a}, 16'd0);
        chk("rst_new_high", {15'd0, nh_a}, 16'd0);
        chk("rst_an", {12'd0, an_a}, {12'd0, 4'b1110});
        chk("rst_seg", {9'd0, seg_a}, {9'd0, 7'b1000000});

        // ---- game A: lockout behaviour ----
        reset = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_playing", {15'd0, play_a}, 16'd1);
        chk("start_score", score_a, 16'h0000);
        chk("start_an", {12'd0, an_a}, {12'd0, 4'b1110});
        chk("start_seg", {9'd0, seg_a}, {9'd0, 7'b1000000});

        inc_a = 1'b1;
        sc_a++;
        push("hold50_single", to_bcd(sc_a));
        repeat (50) tick();
        inc_a = 1'b0;
        repeat (LOCK_A + 2) tick();
        pop_check(score_a);

        sc_a++;
        push("lock_edge_ignored", to_bcd(sc_a));
        ev_a(LOCK_A - 1);
        ev_a(LOCK_A + 1);
        pop_check(score_a);

        sc_a += 2;
        push("lock_expired_counts", to_bcd(sc_a));
        ev_a(LOCK_A);
        ev_a(LOCK_A + 1);
        pop_check(score_a);

        while (sc_a < 99) begin
            ev_a(LOCK_A + 1);
            sc_a++;
        end
        push("preload_99", to_bcd(sc_a));
        pop_check(score_a);
        sc_a++;
        push("carry_0100", to_bcd(sc_a));
        ev_a(LOCK_A + 1);
        pop_check(score_a);
        while (sc_a < 1234) begin
            ev_a(LOCK_A + 1);
            sc_a++;
        end
        push("score_1234", to_bcd(sc_a));
        pop_check(score_a);

        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        chk("over_playing", {15'd0, play_a}, 16'd0);
        chk("over_high", high_a, 16'h1234);
        chk("over_new_high", {15'd0, nh_a}, 16'd1);
        chk("over_score_kept", score_a, 16'h1234);

        // rise in OVER must neither count nor start a lockout
        inc_a = 1'b1;
        tick();
        inc_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_score", score_a, 16'h0000);
        chk("restart_new_high", {15'd0, nh_a}, 16'd0);
        chk("restart_high_kept", high_a, 16'h1234);
        sc_a = 1;
        push("no_lock_outside_play", to_bcd(sc_a));
        ev_a(LOCK_A + 1);
        pop_check(score_a);
        sc_a += 2;
        push("score_0003", to_bcd(sc_a));
        ev_a(LOCK_A + 1);
        ev_a(LOCK_A + 1);
        pop_check(score_a);

        // ---- game B: POINTS=5, priority rules and saturation ----
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_playing", {15'd0, play_b}, 16'd1);
        for (int i = 0; i < 8; i++) begin
            ev_b(2);
            sc_b += 5;
        end
        push("b_score_0040", to_bcd(sc_b));
        pop_check(score_b);

        inc_b = 1'b1;
        go_b  = 1'b1;
        tick();
        inc_b = 1'b0;
        go_b  = 1'b0;
        tick();
        chk("b_drop_on_over", score_b, 16'h0040);
        chk("b_high_pre_event", high_b, 16'h0040);
        chk("b_new_high", {15'd0, nh_b}, 16'd1);

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_restart_new_high", {15'd0, nh_b}, 16'd0);
        sc_b = 0;
        for (int i = 0; i < 3; i++) begin
            ev_b(2);
            sc_b += 5;
        end
        push("b_score_0015", to_bcd(sc_b));
        pop_check(score_b);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_start_ignored", score_b, 16'h0015);
        start_b = 1'b1;
        go_b    = 1'b1;
        tick();
        start_b = 1'b0;
        go_b    = 1'b0;
        chk("b_over_wins", {15'd0, play_b}, 16'd0);
        chk("b_high_kept", high_b, 16'h0040);
        chk("b_no_new_high", {15'd0, nh_b}, 16'd0);

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        sc_b = 0;
        for (int i = 0; i < 1999; i++) begin
            ev_b(2);
            sc_b += 5;
        end
        push("b_score_9995", to_bcd(sc_b));
        pop_check(score_b);
        sc_b += 5;
        push("b_saturate", to_bcd(sc_b));
        ev_b(2);
        pop_check(score_b);
        sc_b += 5;
        push("b_saturate_hold", to_bcd(sc_b));
        ev_b(2);
        pop_check(score_b);
        go_b = 1'b1;
        tick();
        go_b = 1'b0;
        chk("b_high_9999", high_b, 16'h9999);

        // ---- display scan on A: high 1234, score 0003 ----
        dt[0] = '{1'b1, 0, 4'b1110, seg_tab[4]};
        dt[1] = '{1'b1, 1, 4'b1101, seg_tab[3]};
        dt[2] = '{1'b1, 2, 4'b1011, seg_tab[2]};
        dt[3] = '{1'b1, 3, 4'b0111, seg_tab[1]};
        dt[4] = '{1'b0, 0, 4'b1110, seg_tab[3]};
        dt[5] = '{1'b0, 1, 4'b1101, seg_tab[0]};
        dt[6] = '{1'b0, 2, 4'b1011, seg_tab[0]};
        dt[7] = '{1'b0, 3, 4'b0111, seg_tab[0]};
        for (int r = 0; r < 8; r++) begin
            int guard;
            sh_a  = dt[r].sh;
            guard = 0;
            tick();
            while (!(cur_sel() == dt[r].sel && cur_phase() == 0) && guard < 40) begin
                tick();
                guard++;
            end
            if (guard >= 40) begin
                total++;
                bad++;
                $display("FAIL scan_align: got no alignment expected sel %0d", dt[r].sel);
            end
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan_an_r%0d_c%0d", r, c), {12'd0, an_a}, {12'd0, dt[r].an});
                chk($sformatf("scan_seg_r%0d_c%0d", r, c), {9'd0, seg_a}, {9'd0, dt[r].seg});
                if (c < 3) tick();
            end
        end

        // sanity of the scan model against an independent formula mid-scan
        sh_a = 1'b1;
        begin
            int guard;
            guard = 0;
            while (cur_sel() != 2 && guard < 40) begin
                tick();
                guard++;
            end
        end
        chk("pre_reset_an", {12'd0, an_a}, {12'd0, an_for(2)});

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_score", score_a, 16'h0000);
        chk("mid_rst_high", high_a, 16'h0000);
        chk("mid_rst_playing", {15'd0, play_a}, 16'd0);
        chk("mid_rst_new_high", {15'd0, nh_a}, 16'd0);
        chk("mid_rst_an", {12'd0, an_a}, {12'd0, 4'b1110});
        chk("mid_rst_seg", {9'd0, seg_a}, {9'd0, 7'b1000000});
        chk("mid_rst_high_b", high_b, 16'h0000);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
